// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus layouts, write-back select codes
// and the data-memory handshake FSM states.
package mem_stage_pkg;

    localparam int EXE_MEM_W = 75;
    localparam int MEM_WB_W  = 70;

    localparam logic [2:0] WB_SEL_ALU = 3'b000;
    localparam logic [2:0] WB_SEL_MEM = 3'b001;
    localparam logic [2:0] WB_SEL_PC4 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDATA  = 2'd2
    } dmem_state_e;

    // Field order matches the bit layout of the pipeline buses, MSB first.
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
    } exe_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] pc;
    } mem_wb_t;

    function automatic logic [31:0] select_wb(input logic [2:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] rdata,
                                              input logic [31:0] pc);
        logic [31:0] res;
        case (sel)
            WB_SEL_ALU: res = alu;
            WB_SEL_MEM: res = rdata;
            WB_SEL_PC4: res = pc + 32'd4;
            default:    res = 32'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_dmem_if_fsm.sv
// Data-memory handshake controller: IDLE/ACCESS/RDATA FSM, access timeout
// counter, sticky error flag and the complete/abort strobes for the stage.
module mem_stage_dmem_if_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_op_i,
    input  logic        is_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic        complete_o,
    output logic        abort_o,
    output logic        mem_err_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    dmem_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        err_d      = err_q;
        dmem_req_o = 1'b0;
        complete_o = 1'b0;
        abort_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op_i) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) begin
                    if (is_store_i) begin
                        complete_o = 1'b1;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (dmem_rvalid_i) begin
                    complete_o = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A response arriving on the last allowed cycle still wins over the timeout.
        if (state_q != ST_IDLE) begin
            if (complete_o) begin
                state_d = ST_IDLE;
            end else if (cnt_q >= TIMEOUT_LAST) begin
                abort_o = 1'b1;
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign dmem_we_o    = dmem_req_o & is_store_i;
    assign dmem_addr_o  = dmem_req_o ? addr_i : 32'b0;
    assign dmem_wdata_o = dmem_we_o ? wdata_i : 32'b0;
    assign mem_err_o    = err_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage RISC-V pipeline: registers the exe->mem bus,
// performs loads/stores through the dmem handshake and drives the mem->wb bus.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [EXE_MEM_W-1:0] exe_mem_bus_in,
    input  logic [31:0]          exe_store_data,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic [MEM_WB_W-1:0]  mem_wb_bus_out,
    output logic                 mem_err
);

    exe_mem_t    entry_q, entry_d;
    logic [31:0] store_data_q, store_data_d;
    mem_wb_t     wb_q, wb_d;

    logic        mem_op;
    logic        complete;
    logic        abort;
    logic [31:0] wb_data;

    assign mem_op    = entry_q.mem_we | entry_q.mem_re;
    assign mem_stall = mem_op & ~(complete | abort);

    mem_stage_dmem_if_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dmem_if_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_op_i     (mem_op),
        .is_store_i   (entry_q.mem_we),
        .addr_i       ({entry_q.alu_result[31:2], 2'b00}),
        .wdata_i      (store_data_q),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .complete_o   (complete),
        .abort_o      (abort),
        .mem_err_o    (mem_err)
    );

    assign wb_data = select_wb(entry_q.wb_sel, entry_q.alu_result, dmem_rdata, entry_q.pc);

    always_comb begin
        entry_d      = entry_q;
        store_data_d = store_data_q;
        if (!mem_stall) begin
            entry_d      = exe_mem_bus_in;
            store_data_d = exe_store_data;
        end
    end

    // Any cycle the entry does not retire drives a bubble; an aborted access
    // retires with its register write suppressed.
    always_comb begin
        wb_d = '0;
        if (!mem_stall) begin
            wb_d.rd = entry_q.rd;
            wb_d.pc = entry_q.pc;
            if (!abort) begin
                wb_d.wb_data = wb_data;
                wb_d.rd_wen  = entry_q.rd_wen;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q      <= '0;
            store_data_q <= '0;
            wb_q         <= '0;
        end else begin
            entry_q      <= entry_d;
            store_data_q <= store_data_d;
            wb_q         <= wb_d;
        end
    end

    assign mem_wb_bus_out = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed instructions push their expected
// mem->wb beat, a monitor pops and compares every non-bubble output.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [74:0] exe_mem_bus_in;
    logic [31:0] exe_store_data;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [69:0] mem_wb_bus_out;
    logic        mem_err;

    int vectorCount = 0;
    int missCount   = 0;
    logic [69:0] expQ[$];

    mem_stage #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .exe_mem_bus_in(exe_mem_bus_in),
        .exe_store_data(exe_store_data),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_gnt      (dmem_gnt),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .mem_wb_bus_out(mem_wb_bus_out),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [74:0] mkBus(input logic [31:0] alu, input logic [4:0] rd,
                                          input logic wen, input logic we, input logic re,
                                          input logic [2:0] sel, input logic [31:0] pc);
        return {alu, rd, wen, we, re, sel, pc};
    endfunction

    function automatic logic [69:0] mkWb(input logic [31:0] data, input logic [4:0] rd,
                                         input logic wen, input logic [31:0] pc);
        return {data, rd, wen, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [69:0] act, input logic [69:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [74:0] bus, input logic [31:0] sdata,
                                 input bit expectRetire, input logic [69:0] expWb);
        exe_mem_bus_in = bus;
        exe_store_data = sdata;
        if (expectRetire) expQ.push_back(expWb);
    endtask

    task automatic issueNop();
        exe_mem_bus_in = '0;
        exe_store_data = '0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wb_bus_out !== '0) begin
            if (expQ.size() == 0) begin
                vectorCount++;
                missCount++;
                $display("[TB] FAIL unexpected_retire: got %0h, expected no retire", mem_wb_bus_out);
            end else begin
                checkOutput("retire", mem_wb_bus_out, expQ.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stallCount;
        logic bubbleBad;

        rst_n       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        issueNop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_wb_bus", mem_wb_bus_out, '0);
        checkOutput("reset_stall", 70'(mem_stall), '0);
        checkOutput("reset_req", 70'(dmem_req), '0);
        checkOutput("reset_err", 70'(mem_err), '0);
        tick();
        rst_n = 1'b1;

        $display("[TB] ALU pass-through");
        applyStimulus(mkBus(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 32'h10), '0, 1'b1,
                      mkWb(32'h1234, 5'd5, 1'b1, 32'h10));
        tick();
        issueNop();
        @(negedge clk);
        checkOutput("alu_no_stall", 70'(mem_stall), '0);
        tick();
        @(negedge clk);
        checkOutput("alu_latency", mem_wb_bus_out, mkWb(32'h1234, 5'd5, 1'b1, 32'h10));
        tick();

        $display("[TB] wb_sel variants");
        applyStimulus(mkBus(32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b010, 32'h80), '0, 1'b1,
                      mkWb(32'h84, 5'd3, 1'b1, 32'h80));
        tick();
        applyStimulus(mkBus(32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFC), '0, 1'b1,
                      mkWb(32'h0, 5'd4, 1'b1, 32'hFFFF_FFFC));
        tick();
        applyStimulus(mkBus(32'hDEAD, 5'd6, 1'b1, 1'b0, 1'b0, 3'b011, 32'h90), '0, 1'b1,
                      mkWb(32'h0, 5'd6, 1'b1, 32'h90));
        tick();
        issueNop();
        repeat (3) tick();

        $display("[TB] load with delayed gnt");
        applyStimulus(mkBus(32'h40, 5'd7, 1'b1, 1'b0, 1'b1, 3'b001, 32'h200), '0, 1'b1,
                      mkWb(32'hCAFE_F00D, 5'd7, 1'b1, 32'h200));
        tick();
        issueNop();
        stallCount = 0;
        bubbleBad  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            dmem_gnt    = (c == 3);
            dmem_rvalid = (c == 4);
            dmem_rdata  = (c == 4) ? 32'hCAFE_F00D : 32'h0;
            @(negedge clk);
            if (c < 5) begin
                stallCount += int'(mem_stall);
                if (mem_wb_bus_out !== '0) bubbleBad = 1'b1;
            end
            if (c == 1) begin
                checkOutput("load_req", 70'(dmem_req), 70'(1));
                checkOutput("load_addr", 70'(dmem_addr), 70'(32'h40));
                checkOutput("load_we", 70'(dmem_we), '0);
            end
            if (c == 4) checkOutput("load_rdata_req", 70'(dmem_req), '0);
            tick();
        end
        checkOutput("load_stall_cycles", 70'(stallCount), 70'(4));
        checkOutput("load_bubbles", 70'(bubbleBad), '0);

        $display("[TB] store with immediate gnt");
        applyStimulus(mkBus(32'h103, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h300), 32'hA5A5_A5A5, 1'b1,
                      mkWb(32'h103, 5'd0, 1'b0, 32'h300));
        tick();
        issueNop();
        stallCount = 0;
        for (int c = 0; c < 3; c++) begin
            dmem_gnt = (c == 1);
            @(negedge clk);
            if (c < 2) stallCount += int'(mem_stall);
            if (c == 1) begin
                checkOutput("store_req", 70'(dmem_req), 70'(1));
                checkOutput("store_addr", 70'(dmem_addr), 70'(32'h100));
                checkOutput("store_we", 70'(dmem_we), 70'(1));
                checkOutput("store_wdata", 70'(dmem_wdata), 70'(32'hA5A5_A5A5));
            end
            tick();
        end
        checkOutput("store_stall_cycles", 70'(stallCount), 70'(1));

        $display("[TB] load timeout");
        applyStimulus(mkBus(32'h44, 5'd9, 1'b1, 1'b0, 1'b1, 3'b001, 32'h400), '0, 1'b1,
                      mkWb(32'h0, 5'd9, 1'b0, 32'h400));
        tick();
        issueNop();
        stallCount = 0;
        for (int c = 0; c < 6; c++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            @(negedge clk);
            if (c < 4) stallCount += int'(mem_stall);
            if (c == 4) checkOutput("timeout_stall_drop", 70'(mem_stall), '0);
            if (c == 5) checkOutput("timeout_err", 70'(mem_err), 70'(1));
            tick();
        end
        checkOutput("timeout_stall_cycles", 70'(stallCount), 70'(4));

        $display("[TB] reset during access");
        applyStimulus(mkBus(32'h48, 5'd10, 1'b1, 1'b0, 1'b1, 3'b001, 32'h500), '0, 1'b0, '0);
        tick();
        issueNop();
        tick();
        #2;
        checkOutput("midreset_req_before", 70'(dmem_req), 70'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_req", 70'(dmem_req), '0);
        checkOutput("midreset_stall", 70'(mem_stall), '0);
        checkOutput("midreset_err", 70'(mem_err), '0);
        checkOutput("midreset_wb_bus", mem_wb_bus_out, '0);
        tick();
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        @(negedge clk);
        checkOutput("stray_rvalid_req", 70'(dmem_req), '0);
        checkOutput("stray_rvalid_stall", 70'(mem_stall), '0);
        tick();
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        repeat (4) tick();

        checkOutput("scoreboard_drain", 70'(expQ.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
